// File: rtl/register_bank_if.sv
// Bus bundle between the pipeline/debug unit and the register bank:
// writeback port, two decode read ports and the register dump stream.
interface register_bank_if #(
    parameter int NBITS = 32
);
    logic             i_wr_en;
    logic [4:0]       i_reg_sel;
    logic [NBITS-1:0] i_wr_data;
    logic [4:0]       i_rs;
    logic [4:0]       i_rt;
    logic [NBITS-1:0] o_rs_data;
    logic [NBITS-1:0] o_rt_data;
    logic             i_dump_start;
    logic             i_dump_ready;
    logic             o_dump_valid;
    logic [NBITS-1:0] o_dump_data;
    logic [4:0]       o_dump_idx;
    logic             o_dump_busy;
    logic             o_dump_done;

    modport master (
        output i_wr_en, i_reg_sel, i_wr_data, i_rs, i_rt, i_dump_start, i_dump_ready,
        input  o_rs_data, o_rt_data, o_dump_valid, o_dump_data, o_dump_idx,
               o_dump_busy, o_dump_done
    );

    modport slave (
        input  i_wr_en, i_reg_sel, i_wr_data, i_rs, i_rt, i_dump_start, i_dump_ready,
        output o_rs_data, o_rt_data, o_dump_valid, o_dump_data, o_dump_idx,
               o_dump_busy, o_dump_done
    );
endinterface

// File: rtl/register_bank.sv
// MIPS general-purpose register file: one write port, two bypassed
// combinational read ports and a valid/ready stream that dumps all registers.
module register_bank #(
    parameter int NBITS = 32,
    parameter int NREGS = 32
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    register_bank_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

    logic [NBITS-1:0] regs_q [NREGS];
    logic [NBITS-1:0] regs_d [NREGS];
    logic [NREGS-1:0] wr_hit;
    logic             wr_commit;

    state_t           state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [4:0]       idx_inc;
    logic [NBITS-1:0] dump_data_q, dump_data_d;

    assign wr_commit = bus.i_wr_en && (bus.i_reg_sel != 5'd0);

    // Register 0 never gets a hit because wr_commit already excludes it.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_wr_hit
            assign wr_hit[gi] = wr_commit && (bus.i_reg_sel == 5'(gi));
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = wr_hit[i] ? bus.i_wr_data : regs_q[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        bus.o_rs_data = regs_q[bus.i_rs];
        bus.o_rt_data = regs_q[bus.i_rt];
        if (wr_commit && (bus.i_reg_sel == bus.i_rs)) bus.o_rs_data = bus.i_wr_data;
        if (wr_commit && (bus.i_reg_sel == bus.i_rt)) bus.o_rt_data = bus.i_wr_data;
        if (bus.i_rs == 5'd0) bus.o_rs_data = '0;
        if (bus.i_rt == 5'd0) bus.o_rt_data = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 5'd0;
            dump_data_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dump_data_q <= dump_data_d;
        end
    end

    assign idx_inc = idx_q + 5'd1;

    // Loads sample regs_d so a write committing on the same edge is captured.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dump_data_d = dump_data_q;
        case (state_q)
            IDLE: begin
                if (bus.i_dump_start) begin
                    state_d     = SEND;
                    idx_d       = 5'd0;
                    dump_data_d = regs_d[0];
                end
            end
            SEND: begin
                if (bus.i_dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d       = idx_inc;
                        dump_data_d = regs_d[idx_inc];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_dump_valid = (state_q == SEND);
        bus.o_dump_busy  = (state_q == SEND);
        bus.o_dump_done  = (state_q == DONE);
        bus.o_dump_idx   = idx_q;
        bus.o_dump_data  = dump_data_q;
    end
endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: vector table for read/write/bypass,
// hand sequences for the dump stream, stalls and mid-dump reset.
module tb_register_bank;
    logic i_clk = 1'b0;
    logic i_rst_n;
    int   tests  = 0;
    int   failed = 0;

    register_bank_if #(.NBITS(32)) bus ();

    register_bank #(.NBITS(32), .NREGS(32)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        wr_en;
        logic [4:0]  sel;
        logic [31:0] data;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] dump2_exp(input int k);
        if (k == 4) return 32'h000B_EEF4;
        return 32'(k * 32'h11);
    endfunction

    initial begin
        int  exp_idx;
        int  cyc;
        bit  ph;
        bit  finished;

        vecs[0] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd31, 32'h0,         32'h0};
        vecs[1] = '{1'b1, 5'd5,  32'hDEADBEEF,  5'd5,  5'd0,  32'hDEADBEEF,  32'h0};
        vecs[2] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'hDEADBEEF,  32'hDEADBEEF};
        vecs[3] = '{1'b1, 5'd0,  32'h12345678,  5'd0,  5'd5,  32'h0,         32'hDEADBEEF};
        vecs[4] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,         32'h0};
        vecs[5] = '{1'b1, 5'd7,  32'h1,         5'd7,  5'd6,  32'h1,         32'h0};
        vecs[6] = '{1'b1, 5'd7,  32'hA5A5A5A5,  5'd7,  5'd7,  32'hA5A5A5A5,  32'hA5A5A5A5};
        vecs[7] = '{1'b1, 5'd31, 32'hFFFFFFFF,  5'd7,  5'd30, 32'hA5A5A5A5,  32'h0};
        vecs[8] = '{1'b0, 5'd7,  32'h0,         5'd7,  5'd31, 32'hA5A5A5A5,  32'hFFFFFFFF};
        vecs[9] = '{1'b1, 5'd31, 32'h1234,      5'd31, 5'd31, 32'h1234,      32'h1234};

        i_rst_n          = 1'b0;
        bus.i_wr_en      = 1'b0;
        bus.i_reg_sel    = 5'd0;
        bus.i_wr_data    = 32'h0;
        bus.i_rs         = 5'd5;
        bus.i_rt         = 5'd31;
        bus.i_dump_start = 1'b0;
        bus.i_dump_ready = 1'b0;

        repeat (2) @(negedge i_clk);
        check("rst_valid", 32'(bus.o_dump_valid), 32'h0);
        check("rst_busy",  32'(bus.o_dump_busy),  32'h0);
        check("rst_done",  32'(bus.o_dump_done),  32'h0);
        check("rst_idx",   32'(bus.o_dump_idx),   32'h0);
        check("rst_data",  bus.o_dump_data,       32'h0);
        check("rst_rs",    bus.o_rs_data,         32'h0);
        $display("[TB] reset state checked");
        i_rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            bus.i_wr_en   = vecs[i].wr_en;
            bus.i_reg_sel = vecs[i].sel;
            bus.i_wr_data = vecs[i].data;
            bus.i_rs      = vecs[i].rs;
            bus.i_rt      = vecs[i].rt;
            #1;
            check($sformatf("vec%0d_rs", i), bus.o_rs_data, vecs[i].exp_rs);
            check($sformatf("vec%0d_rt", i), bus.o_rt_data, vecs[i].exp_rt);
            $display("[TB] vec %0d wr=%0d sel=%0d rs=%0d rt=%0d -> rs_data=0x%08h rt_data=0x%08h",
                     i, vecs[i].wr_en, vecs[i].sel, vecs[i].rs, vecs[i].rt,
                     bus.o_rs_data, bus.o_rt_data);
        end

        // Dump 1: regs[k] = k*0x11, ready tied high.
        for (int k = 1; k < 32; k++) begin
            @(negedge i_clk);
            bus.i_wr_en   = 1'b1;
            bus.i_reg_sel = 5'(k);
            bus.i_wr_data = 32'(k * 32'h11);
        end
        @(negedge i_clk);
        bus.i_wr_en      = 1'b0;
        bus.i_dump_start = 1'b1;
        bus.i_dump_ready = 1'b1;
        for (int b = 0; b < 32; b++) begin
            @(negedge i_clk);
            bus.i_dump_start = 1'b0;
            check($sformatf("d1_valid%0d", b), 32'(bus.o_dump_valid), 32'h1);
            check($sformatf("d1_idx%0d", b),   32'(bus.o_dump_idx),   32'(b));
            check($sformatf("d1_data%0d", b),  bus.o_dump_data,       32'(b * 32'h11));
            $display("[TB] dump1 beat idx=%0d data=0x%08h", bus.o_dump_idx, bus.o_dump_data);
        end
        @(negedge i_clk);
        check("d1_done",       32'(bus.o_dump_done),  32'h1);
        check("d1_done_valid", 32'(bus.o_dump_valid), 32'h0);
        check("d1_done_busy",  32'(bus.o_dump_busy),  32'h0);
        @(negedge i_clk);
        check("d1_done_pulse", 32'(bus.o_dump_done),  32'h0);
        $display("[TB] dump1 done pulse checked");

        // Dump 2: ready alternates 0/1; writes to reg 3 while held and reg 4 on advance.
        bus.i_dump_start = 1'b1;
        bus.i_dump_ready = 1'b0;
        exp_idx  = 0;
        cyc      = 0;
        ph       = 1'b0;
        finished = 1'b0;
        while (!finished && cyc < 200) begin
            @(negedge i_clk);
            cyc++;
            bus.i_dump_start = 1'b0;
            bus.i_wr_en      = 1'b0;
            check($sformatf("d2_valid_c%0d", cyc), 32'(bus.o_dump_valid), 32'h1);
            check($sformatf("d2_idx_c%0d", cyc),   32'(bus.o_dump_idx),   32'(exp_idx));
            check($sformatf("d2_data_c%0d", cyc),  bus.o_dump_data,       dump2_exp(exp_idx));
            $display("[TB] dump2 cyc=%0d ready=%0d idx=%0d data=0x%08h",
                     cyc, ph, bus.o_dump_idx, bus.o_dump_data);
            bus.i_dump_ready = ph;
            if (exp_idx == 3 && !ph) begin
                bus.i_wr_en = 1'b1; bus.i_reg_sel = 5'd3; bus.i_wr_data = 32'h0000CAFE;
            end
            if (exp_idx == 3 && ph) begin
                bus.i_wr_en = 1'b1; bus.i_reg_sel = 5'd4; bus.i_wr_data = 32'h000BEEF4;
            end
            if (ph) begin
                if (exp_idx == 31) finished = 1'b1;
                else exp_idx++;
            end
            ph = !ph;
        end
        if (!finished) check("d2_timeout", 32'(exp_idx), 32'd31);
        @(negedge i_clk);
        bus.i_wr_en      = 1'b0;
        bus.i_dump_ready = 1'b0;
        bus.i_rs         = 5'd3;
        bus.i_rt         = 5'd4;
        #1;
        check("d2_done",   32'(bus.o_dump_done), 32'h1);
        check("d2_reg3",   bus.o_rs_data,        32'h0000CAFE);
        check("d2_reg4",   bus.o_rt_data,        32'h000BEEF4);
        $display("[TB] dump2 done, reg3=0x%08h reg4=0x%08h", bus.o_rs_data, bus.o_rt_data);

        // Dump 3: reset asserted at idx 10, then restart from idx 0.
        @(negedge i_clk);
        bus.i_dump_start = 1'b1;
        bus.i_dump_ready = 1'b1;
        @(negedge i_clk);
        bus.i_dump_start = 1'b0;
        repeat (10) @(negedge i_clk);
        check("d3_idx10",  32'(bus.o_dump_idx), 32'd10);
        check("d3_data10", bus.o_dump_data,     32'h000000AA);
        bus.i_rs = 5'd3;
        bus.i_rt = 5'd31;
        i_rst_n  = 1'b0;
        #1;
        check("d3_rst_valid", 32'(bus.o_dump_valid), 32'h0);
        check("d3_rst_busy",  32'(bus.o_dump_busy),  32'h0);
        check("d3_rst_done",  32'(bus.o_dump_done),  32'h0);
        check("d3_rst_idx",   32'(bus.o_dump_idx),   32'h0);
        check("d3_rst_data",  bus.o_dump_data,       32'h0);
        check("d3_rst_rs",    bus.o_rs_data,         32'h0);
        check("d3_rst_rt",    bus.o_rt_data,         32'h0);
        $display("[TB] dump3 reset at idx 10 checked");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            check($sformatf("d3_no_done%0d", c), 32'(bus.o_dump_done), 32'h0);
        end
        bus.i_dump_start = 1'b1;
        @(negedge i_clk);
        bus.i_dump_start = 1'b0;
        check("d3_restart_valid", 32'(bus.o_dump_valid), 32'h1);
        check("d3_restart_idx0",  32'(bus.o_dump_idx),   32'h0);
        check("d3_restart_data0", bus.o_dump_data,       32'h0);
        @(negedge i_clk);
        check("d3_restart_idx1",  32'(bus.o_dump_idx),   32'h1);
        check("d3_restart_data1", bus.o_dump_data,       32'h0);
        $display("[TB] dump3 restart idx=%0d data=0x%08h", bus.o_dump_idx, bus.o_dump_data);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
